maf_operand_issue: RTL and testbench

- Front end of the MAF pipeline: the producing end of the operand interface whose consuming end is the T5 result stage.
- Accepts raw A, B, C operands and a control word over a valid/ready handshake, buffers them in a 2-entry skid FIFO, then unpacks and classifies them.
- Issues the T1-side control, sign and trap fields that the pipeline carries through to T4/T5.
- Handles both single FP32 and dual packed-FP16 modes.

---
 rtl/maf_operand_issue_pkg.sv | 64 ++++++
 rtl/maf_special_classify.sv | 74 +++++++
 rtl/maf_operand_issue.sv | 196 +++++++++++++++++++
 tb/tb_maf_operand_issue.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/maf_operand_issue_pkg.sv
// Shared encodings for the MAF operand-issue front end: control word fields,
// special-case flag indices, forced-result codes and the issue slot layout.
package maf_operand_issue_pkg;

  localparam int MODE_DUAL = 0;

  localparam logic [1:0] OP_FMA  = 2'b00;  //  A*B+C
  localparam logic [1:0] OP_FMS  = 2'b01;  //  A*B-C
  localparam logic [1:0] OP_FNMA = 2'b10;  // -(A*B)+C
  localparam logic [1:0] OP_RSVD = 2'b11;

  localparam int TRAP_W     = 4;
  localparam int TRAP_NAN   = 0;
  localparam int TRAP_INV   = 1;
  localparam int TRAP_INF   = 2;
  localparam int TRAP_PZERO = 3;

  localparam int ANS_W = 3;
  localparam logic [ANS_W-1:0] ANS_NONE  = 3'b000;
  localparam logic [ANS_W-1:0] ANS_QNAN  = 3'b001;
  localparam logic [ANS_W-1:0] ANS_PINF  = 3'b010;
  localparam logic [ANS_W-1:0] ANS_NINF  = 3'b011;
  localparam logic [ANS_W-1:0] ANS_PASSC = 3'b100;
  localparam logic [ANS_W-1:0] ANS_ZERO  = 3'b101;

  localparam int FP32_EXP_W = 8;
  localparam int FP32_MAN_W = 23;
  localparam int FP16_EXP_W = 5;
  localparam int FP16_MAN_W = 10;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [2:0]  cont;
  } issue_req_t;

  typedef struct packed {
    logic [2:0]        cont;
    logic              s_a;
    logic              s_b;
    logic              s_c;
    logic              s_a_h;
    logic              s_b_h;
    logic              s_c_h;
    logic [TRAP_W-1:0] trap0;
    logic [TRAP_W-1:0] trap1;
    logic [ANS_W-1:0]  ans0;
    logic [ANS_W-1:0]  ans1;
    logic [31:0]       a;
    logic [31:0]       b;
    logic [31:0]       c;
  } issue_slot_t;

  // Magnitude-only view of an operand; in dual mode both lane sign bits go.
  function automatic logic [31:0] strip_signs(input logic [31:0] x, input logic dual);
    logic [31:0] r;
    r = x;
    r[31] = 1'b0;
    if (dual) r[15] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/maf_special_classify.sv
// Special-operand classifier for one lane: flags NaN/invalid/inf/zero-product
// and picks the forced-result code from the effective signs.
module maf_special_classify
  import maf_operand_issue_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W-1:0] a_mag,
  input  logic [EXP_W+MAN_W-1:0] b_mag,
  input  logic [EXP_W+MAN_W-1:0] c_mag,
  input  logic                   s_a,
  input  logic                   s_b,
  input  logic                   s_c,
  output logic [TRAP_W-1:0]      trap,
  output logic [ANS_W-1:0]       ans
);

  localparam int MAG_W = EXP_W + MAN_W;

  logic a_emax, b_emax, c_emax;
  logic a_mzero, b_mzero, c_mzero;
  logic nan_a, nan_b, nan_c;
  logic inf_a, inf_b, inf_c;
  logic zero_a, zero_b, zero_c;
  logic s_p, prod_inf;
  logic any_nan, invalid, any_inf, prod_zero;

  assign a_emax  = &a_mag[MAG_W-1:MAN_W];
  assign b_emax  = &b_mag[MAG_W-1:MAN_W];
  assign c_emax  = &c_mag[MAG_W-1:MAN_W];
  assign a_mzero = ~|a_mag[MAN_W-1:0];
  assign b_mzero = ~|b_mag[MAN_W-1:0];
  assign c_mzero = ~|c_mag[MAN_W-1:0];

  assign nan_a = a_emax & ~a_mzero;
  assign nan_b = b_emax & ~b_mzero;
  assign nan_c = c_emax & ~c_mzero;
  assign inf_a = a_emax & a_mzero;
  assign inf_b = b_emax & b_mzero;
  assign inf_c = c_emax & c_mzero;

  // Denormals are flushed, so a zero exponent counts as zero.
  assign zero_a = ~|a_mag[MAG_W-1:MAN_W];
  assign zero_b = ~|b_mag[MAG_W-1:MAN_W];
  assign zero_c = ~|c_mag[MAG_W-1:MAN_W];

  assign s_p      = s_a ^ s_b;
  assign prod_inf = inf_a | inf_b;

  assign any_nan   = nan_a | nan_b | nan_c;
  assign invalid   = (inf_a & zero_b) | (zero_a & inf_b) | (prod_inf & inf_c & (s_p != s_c));
  assign any_inf   = prod_inf | inf_c;
  // inf*0 and NaN products are not zero products.
  assign prod_zero = (zero_a | zero_b) & ~prod_inf & ~nan_a & ~nan_b;

  always_comb begin
    trap             = '0;
    trap[TRAP_NAN]   = any_nan;
    trap[TRAP_INV]   = invalid;
    trap[TRAP_INF]   = any_inf;
    trap[TRAP_PZERO] = prod_zero;

    ans = ANS_NONE;
    if (any_nan || invalid) begin
      ans = ANS_QNAN;
    end else if (any_inf) begin
      ans = (prod_inf ? s_p : s_c) ? ANS_NINF : ANS_PINF;
    end else if (prod_zero) begin
      ans = zero_c ? ANS_ZERO : ANS_PASSC;
    end
  end

endmodule

// File: rtl/maf_operand_issue.sv
// MAF operand issue stage: skid FIFO in front of a registered issue slot that
// carries unpacked operands, effective signs and per-lane special-case codes.
module maf_operand_issue
  import maf_operand_issue_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_a,
  input  logic [31:0]       in_b,
  input  logic [31:0]       in_c,
  input  logic [2:0]        in_cont,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        cont_T1,
  output logic              S_A_T1,
  output logic              S_B_T1,
  output logic              S_C_T1,
  output logic              S_A_H_T1,
  output logic              S_B_H_T1,
  output logic              S_C_H_T1,
  output logic [3:0]        trap_T1_0,
  output logic [3:0]        trap_T1_1,
  output logic [2:0]        trap_ans_T1_0,
  output logic [2:0]        trap_ans_T1_1,
  output logic [31:0]       a_T1,
  output logic [31:0]       b_T1,
  output logic [31:0]       c_T1,
  output logic [TAG_W-1:0]  tag_T1,
  output logic              illegal
);

  // DEPTH must be a power of two so the pointers wrap by plain overflow.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  issue_req_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count, count_nxt;
  logic             full_q;
  logic [TAG_W-1:0] tag_q;

  logic       push, load, fifo_empty, bypass, fifo_wr, fifo_rd, src_valid;
  issue_req_t req_in, src;

  assign req_in     = '{a: in_a, b: in_b, c: in_c, cont: in_cont};
  assign in_ready   = ~full_q;
  assign push       = in_valid & in_ready;
  assign load       = ~out_valid | out_ready;
  assign fifo_empty = (count == '0);
  assign bypass     = push & fifo_empty & load;
  assign fifo_wr    = push & ~bypass;
  assign fifo_rd    = load & ~fifo_empty;
  assign src_valid  = ~fifo_empty | push;
  assign src        = fifo_empty ? req_in : mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (fifo_wr && !fifo_rd)      count_nxt = count + CNT_W'(1);
    else if (!fifo_wr && fifo_rd) count_nxt = count - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) mem[wr_ptr] <= req_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full_q <= 1'b0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (fifo_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      count  <= count_nxt;
      full_q <= (count_nxt == CNT_W'(DEPTH));
    end
  end

  // Decode of the selected head; reserved op travels as a plain FMA.
  logic [1:0] op_raw, op_eff;
  logic       rsvd, dual, neg_a, neg_c;
  logic       sa_h, sb_h, sc_h, sa_l, sb_l, sc_l;

  assign op_raw = src.cont[2:1];
  assign rsvd   = (op_raw == OP_RSVD);
  assign op_eff = rsvd ? OP_FMA : op_raw;
  assign dual   = src.cont[MODE_DUAL];
  assign neg_a  = (op_eff == OP_FNMA);
  assign neg_c  = (op_eff == OP_FMS);

  assign sa_h = src.a[31] ^ neg_a;
  assign sb_h = src.b[31];
  assign sc_h = src.c[31] ^ neg_c;
  assign sa_l = src.a[15] ^ neg_a;
  assign sb_l = src.b[15];
  assign sc_l = src.c[15] ^ neg_c;

  logic [TRAP_W-1:0] trap_32, trap_h, trap_l;
  logic [ANS_W-1:0]  ans_32, ans_h, ans_l;

  maf_special_classify #(.EXP_W(FP32_EXP_W), .MAN_W(FP32_MAN_W)) u_cls_fp32 (
    .a_mag (src.a[30:0]),
    .b_mag (src.b[30:0]),
    .c_mag (src.c[30:0]),
    .s_a   (sa_h),
    .s_b   (sb_h),
    .s_c   (sc_h),
    .trap  (trap_32),
    .ans   (ans_32)
  );

  maf_special_classify #(.EXP_W(FP16_EXP_W), .MAN_W(FP16_MAN_W)) u_cls_fp16_h (
    .a_mag (src.a[30:16]),
    .b_mag (src.b[30:16]),
    .c_mag (src.c[30:16]),
    .s_a   (sa_h),
    .s_b   (sb_h),
    .s_c   (sc_h),
    .trap  (trap_h),
    .ans   (ans_h)
  );

  maf_special_classify #(.EXP_W(FP16_EXP_W), .MAN_W(FP16_MAN_W)) u_cls_fp16_l (
    .a_mag (src.a[14:0]),
    .b_mag (src.b[14:0]),
    .c_mag (src.c[14:0]),
    .s_a   (sa_l),
    .s_b   (sb_l),
    .s_c   (sc_l),
    .trap  (trap_l),
    .ans   (ans_l)
  );

  issue_slot_t slot_nxt, slot_q;

  always_comb begin
    slot_nxt       = '0;
    slot_nxt.cont  = {op_eff, dual};
    slot_nxt.s_a   = dual ? sa_l : sa_h;
    slot_nxt.s_b   = dual ? sb_l : sb_h;
    slot_nxt.s_c   = dual ? sc_l : sc_h;
    slot_nxt.s_a_h = dual & sa_h;
    slot_nxt.s_b_h = dual & sb_h;
    slot_nxt.s_c_h = dual & sc_h;
    slot_nxt.trap0 = dual ? trap_l : trap_32;
    slot_nxt.ans0  = dual ? ans_l : ans_32;
    slot_nxt.trap1 = dual ? trap_h : '0;
    slot_nxt.ans1  = dual ? ans_h : ANS_NONE;
    if (rsvd) begin
      slot_nxt.ans0 = ANS_QNAN;
      slot_nxt.ans1 = ANS_QNAN;
    end
    slot_nxt.a = strip_signs(src.a, dual);
    slot_nxt.b = strip_signs(src.b, dual);
    slot_nxt.c = strip_signs(src.c, dual);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q    <= '0;
      out_valid <= 1'b0;
      tag_q     <= '0;
      illegal   <= 1'b0;
    end else begin
      illegal <= push & (in_cont[2:1] == OP_RSVD);
      if (out_valid && out_ready) tag_q <= tag_q + TAG_W'(1);
      if (load) begin
        out_valid <= src_valid;
        if (src_valid) slot_q <= slot_nxt;
      end
    end
  end

  assign cont_T1       = slot_q.cont;
  assign S_A_T1        = slot_q.s_a;
  assign S_B_T1        = slot_q.s_b;
  assign S_C_T1        = slot_q.s_c;
  assign S_A_H_T1      = slot_q.s_a_h;
  assign S_B_H_T1      = slot_q.s_b_h;
  assign S_C_H_T1      = slot_q.s_c_h;
  assign trap_T1_0     = slot_q.trap0;
  assign trap_T1_1     = slot_q.trap1;
  assign trap_ans_T1_0 = slot_q.ans0;
  assign trap_ans_T1_1 = slot_q.ans1;
  assign a_T1          = slot_q.a;
  assign b_T1          = slot_q.b;
  assign c_T1          = slot_q.c;
  assign tag_T1        = tag_q;

endmodule

// File: tb/tb_maf_operand_issue.sv
// Directed bench for maf_operand_issue: hand-computed vectors for flow control,
// sign folding, per-lane classification, throughput and mid-stream reset.
module tb_maf_operand_issue;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b, in_c;
  logic [2:0]  in_cont;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  cont_T1;
  logic        S_A_T1, S_B_T1, S_C_T1, S_A_H_T1, S_B_H_T1, S_C_H_T1;
  logic [3:0]  trap_T1_0, trap_T1_1;
  logic [2:0]  trap_ans_T1_0, trap_ans_T1_1;
  logic [31:0] a_T1, b_T1, c_T1;
  logic [3:0]  tag_T1;
  logic        illegal;

  int n_checks = 0;
  int n_fails  = 0;

  maf_operand_issue #(.DEPTH(2), .TAG_W(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_a          (in_a),
    .in_b          (in_b),
    .in_c          (in_c),
    .in_cont       (in_cont),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .cont_T1       (cont_T1),
    .S_A_T1        (S_A_T1),
    .S_B_T1        (S_B_T1),
    .S_C_T1        (S_C_T1),
    .S_A_H_T1      (S_A_H_T1),
    .S_B_H_T1      (S_B_H_T1),
    .S_C_H_T1      (S_C_H_T1),
    .trap_T1_0     (trap_T1_0),
    .trap_T1_1     (trap_T1_1),
    .trap_ans_T1_0 (trap_ans_T1_0),
    .trap_ans_T1_1 (trap_ans_T1_1),
    .a_T1          (a_T1),
    .b_T1          (b_T1),
    .c_T1          (c_T1),
    .tag_T1        (tag_T1),
    .illegal       (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                      input logic [2:0] cont);
    int n;
    in_a = a; in_b = b; in_c = c; in_cont = cont; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_val("push_wait", (n < 20), 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pop_check(input string name, input logic [31:0] e_a, input logic [3:0] e_tag);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_val({name, "_wait"}, (n < 20), 1);
    check_val({name, "_a"}, a_T1, e_a);
    check_val({name, "_tag"}, tag_T1, e_tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_vec(input string name,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         input logic [2:0] cont, input logic [2:0] e_cont, input logic [5:0] e_sign,
                         input logic [3:0] e_t0, input logic [2:0] e_a0,
                         input logic [3:0] e_t1, input logic [2:0] e_a1,
                         input logic [31:0] e_a, input logic [31:0] e_c, input logic e_ill);
    out_ready = 1'b0;
    push(a, b, c, cont);
    check_val({name, "_valid"}, out_valid, 1);
    check_val({name, "_cont"}, cont_T1, e_cont);
    check_val({name, "_signs"}, {S_A_T1, S_B_T1, S_C_T1, S_A_H_T1, S_B_H_T1, S_C_H_T1}, e_sign);
    check_val({name, "_trap0"}, trap_T1_0, e_t0);
    check_val({name, "_ans0"}, trap_ans_T1_0, e_a0);
    check_val({name, "_trap1"}, trap_T1_1, e_t1);
    check_val({name, "_ans1"}, trap_ans_T1_1, e_a1);
    check_val({name, "_a"}, a_T1, e_a);
    check_val({name, "_c"}, c_T1, e_c);
    check_val({name, "_illegal"}, illegal, e_ill);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_val({name, "_illegal_clr"}, illegal, 0);
    check_val({name, "_drained"}, out_valid, 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_c = '0; in_cont = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_tag", tag_T1, 0);
    check_val("rst_a", a_T1, 0);
    check_val("rst_trap0", trap_T1_0, 0);
    check_val("rst_illegal", illegal, 0);
    rst = 1'b0;
    @(negedge clk);
    check_val("rst_in_ready", in_ready, 1);

    // Single push with backpressure, then two more to fill the buffer.
    push(32'h3F80_0000, 32'h4000_0000, 32'h3F80_0000, 3'b000);
    check_val("basic_valid", out_valid, 1);
    check_val("basic_signs", {S_A_T1, S_B_T1, S_C_T1, S_A_H_T1, S_B_H_T1, S_C_H_T1}, 0);
    check_val("basic_trap0", trap_T1_0, 4'b0000);
    check_val("basic_ans0", trap_ans_T1_0, 3'b000);
    check_val("basic_trap1", trap_T1_1, 4'b0000);
    check_val("basic_tag", tag_T1, 0);
    check_val("basic_b", b_T1, 32'h4000_0000);
    push(32'h4000_0000, 32'h3F80_0000, 32'h0, 3'b000);
    push(32'h4040_0000, 32'h3F80_0000, 32'h0, 3'b000);
    check_val("bp_full", in_ready, 0);
    check_val("bp_hold_a", a_T1, 32'h3F80_0000);
    check_val("bp_hold_valid", out_valid, 1);
    pop_check("bp_pop0", 32'h3F80_0000, 4'd0);
    check_val("bp_ready_back", in_ready, 1);
    pop_check("bp_pop1", 32'h4000_0000, 4'd1);
    pop_check("bp_pop2", 32'h4040_0000, 4'd2);
    check_val("bp_empty", out_valid, 0);

    //      name        A             B             C             cont    econt   signs      t0       a0      t1       a1      a_T1          c_T1          ill
    run_vec("inv",      32'h7F800000, 32'h00000000, 32'h00000000, 3'b000, 3'b000, 6'b000000, 4'b0110, 3'b001, 4'b0000, 3'b000, 32'h7F800000, 32'h00000000, 1'b0);
    run_vec("dual",     32'h7E003C00, 32'h3C003C00, 32'h00000000, 3'b001, 3'b001, 6'b000000, 4'b0000, 3'b000, 4'b0001, 3'b001, 32'h7E003C00, 32'h00000000, 1'b0);
    run_vec("sub_c",    32'h3F800000, 32'h40000000, 32'h3F800000, 3'b010, 3'b010, 6'b001000, 4'b0000, 3'b000, 4'b0000, 3'b000, 32'h3F800000, 32'h3F800000, 1'b0);
    run_vec("neg_p",    32'h3F800000, 32'h40000000, 32'h3F800000, 3'b100, 3'b100, 6'b100000, 4'b0000, 3'b000, 4'b0000, 3'b000, 32'h3F800000, 32'h3F800000, 1'b0);
    run_vec("neg_a",    32'hBF800000, 32'h40000000, 32'h3F800000, 3'b000, 3'b000, 6'b100000, 4'b0000, 3'b000, 4'b0000, 3'b000, 32'h3F800000, 32'h3F800000, 1'b0);
    run_vec("pinf",     32'h7F800000, 32'h3F800000, 32'h3F800000, 3'b000, 3'b000, 6'b000000, 4'b0100, 3'b010, 4'b0000, 3'b000, 32'h7F800000, 32'h3F800000, 1'b0);
    run_vec("ninf",     32'hFF800000, 32'h3F800000, 32'h3F800000, 3'b000, 3'b000, 6'b100000, 4'b0100, 3'b011, 4'b0000, 3'b000, 32'h7F800000, 32'h3F800000, 1'b0);
    run_vec("inf_inf",  32'h7F800000, 32'h3F800000, 32'hFF800000, 3'b000, 3'b000, 6'b001000, 4'b0110, 3'b001, 4'b0000, 3'b000, 32'h7F800000, 32'h7F800000, 1'b0);
    run_vec("inf_same", 32'h7F800000, 32'h3F800000, 32'hFF800000, 3'b010, 3'b010, 6'b000000, 4'b0100, 3'b010, 4'b0000, 3'b000, 32'h7F800000, 32'h7F800000, 1'b0);
    run_vec("c_inf",    32'h3F800000, 32'h3F800000, 32'h7F800000, 3'b010, 3'b010, 6'b001000, 4'b0100, 3'b011, 4'b0000, 3'b000, 32'h3F800000, 32'h7F800000, 1'b0);
    run_vec("pass_c",   32'h00000000, 32'h3F800000, 32'h3F800000, 3'b000, 3'b000, 6'b000000, 4'b1000, 3'b100, 4'b0000, 3'b000, 32'h00000000, 32'h3F800000, 1'b0);
    run_vec("zero",     32'h00000000, 32'h00000000, 32'h00000000, 3'b000, 3'b000, 6'b000000, 4'b1000, 3'b101, 4'b0000, 3'b000, 32'h00000000, 32'h00000000, 1'b0);
    run_vec("denorm",   32'h00000001, 32'h3F800000, 32'h3F800000, 3'b000, 3'b000, 6'b000000, 4'b1000, 3'b100, 4'b0000, 3'b000, 32'h00000001, 32'h3F800000, 1'b0);
    run_vec("dual_sgn", 32'h3C00BC00, 32'h3C003C00, 32'h00000000, 3'b101, 3'b101, 6'b000100, 4'b0000, 3'b000, 4'b0000, 3'b000, 32'h3C003C00, 32'h00000000, 1'b0);
    run_vec("dual_ninf",32'h3C00FC00, 32'h3C003C00, 32'h00000000, 3'b001, 3'b001, 6'b100000, 4'b0100, 3'b011, 4'b0000, 3'b000, 32'h3C007C00, 32'h00000000, 1'b0);
    run_vec("rsvd",     32'h3F800000, 32'h40000000, 32'h3F800000, 3'b110, 3'b000, 6'b000000, 4'b0000, 3'b001, 4'b0000, 3'b001, 32'h3F800000, 32'h3F800000, 1'b1);

    // Back-to-back pushes with out_ready held: one issue per cycle.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_a = 32'h3F80_0000 + 32'(i); in_b = 32'h3F80_0000; in_c = '0; in_cont = 3'b000;
      check_val("thru_ready", in_ready, 1);
      @(negedge clk);
      check_val("thru_valid", out_valid, 1);
      check_val("thru_a", a_T1, 32'h3F80_0000 + 32'(i));
    end
    in_valid = 1'b0;
    @(negedge clk);
    check_val("thru_drained", out_valid, 0);
    out_ready = 1'b0;

    // Reset with the buffer full: nothing stale may reappear afterwards.
    push(32'h4080_0000, 32'h3F80_0000, 32'h0, 3'b000);
    push(32'h4090_0000, 32'h3F80_0000, 32'h0, 3'b000);
    push(32'h40A0_0000, 32'h3F80_0000, 32'h0, 3'b000);
    check_val("mid_full", in_ready, 0);
    check_val("mid_tag_before", tag_T1, 4'd7);
    rst = 1'b1;
    #1;
    check_val("mid_rst_valid", out_valid, 0);
    check_val("mid_rst_tag", tag_T1, 0);
    check_val("mid_rst_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("mid_no_stale", out_valid, 0);
    end
    out_ready = 1'b0;
    push(32'h40C0_0000, 32'h3F80_0000, 32'h0, 3'b000);
    pop_check("mid_restart", 32'h40C0_0000, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
